// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter with optional parity bit.
// Bytes pushed by the host are queued and sent LSB-first, frames back-to-back.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT    = 217,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter bit PARITY_EN       = 1'b0,
    parameter bit PARITY_ODD      = 1'b0
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_L,
    input  logic                     i_Wr_En,
    input  logic [7:0]               i_Wr_Byte,
    input  logic                     i_Clr_Ovf,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [FIFO_DEPTH_LOG2:0] o_Count,
    output logic                     o_Overflow,
    output logic                     o_TX_Serial,
    output logic                     o_TX_Active,
    output logic                     o_TX_Done
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int CW    = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CW-1:0]    LAST_CLK = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic                       r_full;
    logic                       r_empty;
    logic                       r_ovf;

    logic [2:0]    r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx_serial;
    logic          r_tx_active;
    logic          r_stop_end;
    logic          r_done;

    logic             w_wr_ok;
    logic             w_bit_end;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_next;

    assign w_wr_ok   = i_Wr_En & ~r_full;
    assign w_bit_end = (r_clk_cnt == LAST_CLK);
    // Pop decisions use the registered count, so a same-cycle write is never popped.
    assign w_pop     = (r_count != '0) &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    always_comb begin
        w_count_next = r_count;
        if (w_wr_ok && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_wr_ok && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
            // A dropped write outranks a clear in the same cycle.
            if (i_Wr_En && r_full) begin
                r_ovf <= 1'b1;
            end else if (i_Clr_Ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_tx_serial <= 1'b1;
            r_tx_active <= 1'b0;
            r_stop_end  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_stop_end <= (r_state == STOP) && w_bit_end;
            r_done     <= r_stop_end;
            case (r_state)
                IDLE: begin
                    r_tx_serial <= 1'b1;
                    r_clk_cnt   <= '0;
                    if (w_pop) begin
                        r_shift     <= r_mem[r_rd_ptr];
                        r_bit_idx   <= 3'd0;
                        r_tx_active <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_tx_serial <= 1'b0;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    r_tx_serial <= r_shift[r_bit_idx];
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    r_tx_serial <= (^r_shift) ^ PARITY_ODD;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    r_tx_serial <= 1'b1;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (w_pop) begin
                            r_shift   <= r_mem[r_rd_ptr];
                            r_bit_idx <= 3'd0;
                            r_state   <= START;
                        end else begin
                            r_tx_active <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_serial <= 1'b1;
                    r_tx_active <= 1'b0;
                    r_clk_cnt   <= '0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_Full      = r_full;
    assign o_Empty     = r_empty;
    assign o_Count     = r_count;
    assign o_Overflow  = r_ovf;
    assign o_TX_Serial = r_tx_serial;
    assign o_TX_Active = r_tx_active;
    assign o_TX_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: one 8N1 instance plus even/odd parity instances.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic       p_wr_en;
    logic [7:0] wr_byte;
    logic       clr_ovf;

    logic       full, empty, ovf;
    logic [4:0] count;
    logic [2:0] ser, act, done;
    logic [2:1] p_full, p_empty, p_ovf;
    logic [4:0] p_count1, p_count2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n0, n0b, n0c, c0, n1, c1, n2, c2, lows;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH_LOG2(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    u_dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_En(wr_en), .i_Wr_Byte(wr_byte),
        .i_Clr_Ovf(clr_ovf), .o_Full(full), .o_Empty(empty), .o_Count(count),
        .o_Overflow(ovf), .o_TX_Serial(ser[0]), .o_TX_Active(act[0]), .o_TX_Done(done[0])
    );

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH_LOG2(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    u_dut_even (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_En(p_wr_en), .i_Wr_Byte(wr_byte),
        .i_Clr_Ovf(1'b0), .o_Full(p_full[1]), .o_Empty(p_empty[1]), .o_Count(p_count1),
        .o_Overflow(p_ovf[1]), .o_TX_Serial(ser[1]), .o_TX_Active(act[1]), .o_TX_Done(done[1])
    );

    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH_LOG2(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
    u_dut_odd (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_En(p_wr_en), .i_Wr_Byte(wr_byte),
        .i_Clr_Ovf(1'b0), .o_Full(p_full[2]), .o_Empty(p_empty[2]), .o_Count(p_count2),
        .o_Overflow(p_ovf[2]), .o_TX_Serial(ser[2]), .o_TX_Active(act[2]), .o_TX_Done(done[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit on line sel, then samples each bit in its third clock.
    task automatic rx_frame(input int sel, input logic [7:0] exp_b, input bit par_en,
                            input logic exp_par, input string tag, output int start_cyc);
        int t;
        logic [7:0] got;
        t = 0;
        while (ser[sel] !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        start_cyc = cyc;
        chk({tag, " start"}, {31'b0, ser[sel]}, 32'd0);
        repeat (2) @(negedge clk);
        chk({tag, " start mid"}, {31'b0, ser[sel]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            got[i] = ser[sel];
        end
        chk({tag, " data"}, {24'b0, got}, {24'b0, exp_b});
        if (par_en) begin
            repeat (4) @(negedge clk);
            chk({tag, " parity"}, {31'b0, ser[sel]}, {31'b0, exp_par});
        end
        repeat (4) @(negedge clk);
        chk({tag, " stop"}, {31'b0, ser[sel]}, 32'd1);
    endtask

    task automatic wait_done(input int sel, output int done_cyc);
        int t;
        t = 0;
        while (done[sel] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        done_cyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        p_wr_en = 1'b0;
        wr_byte = 8'h00;
        clr_ovf = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst serial", {31'b0, ser[0]}, 32'd1);
        chk("rst active", {31'b0, act[0]}, 32'd0);
        chk("rst done", {31'b0, done[0]}, 32'd0);
        chk("rst empty", {31'b0, empty}, 32'd1);
        chk("rst full", {31'b0, full}, 32'd0);
        chk("rst count", {27'b0, count}, 32'd0);
        chk("rst ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: single byte 0x55 from idle, latency and done timing
        wr_en = 1'b1; wr_byte = 8'h55;
        @(negedge clk); wr_en = 1'b0;
        chk("t1 count after write", {27'b0, count}, 32'd1);
        chk("t1 empty after write", {31'b0, empty}, 32'd0);
        chk("t1 serial E+1", {31'b0, ser[0]}, 32'd1);
        @(negedge clk);
        chk("t1 count after pop", {27'b0, count}, 32'd0);
        chk("t1 active after pop", {31'b0, act[0]}, 32'd1);
        chk("t1 serial still high", {31'b0, ser[0]}, 32'd1);
        @(negedge clk);
        chk("t1 serial low at E+2", {31'b0, ser[0]}, 32'd0);
        rx_frame(0, 8'h55, 1'b0, 1'b0, "t1", n0);
        wait_done(0, c0);
        chk("t1 done delay", c0 - n0, 32'd40);
        @(negedge clk);
        chk("t1 done single pulse", {31'b0, done[0]}, 32'd0);
        chk("t1 active idle", {31'b0, act[0]}, 32'd0);
        chk("t1 serial idle", {31'b0, ser[0]}, 32'd1);
        repeat (5) @(negedge clk);

        // Test 2 + 6: three consecutive writes; second lands on the pop cycle
        wr_en = 1'b1; wr_byte = 8'hA5;
        @(negedge clk); wr_byte = 8'h3C;
        chk("t2 count 1", {27'b0, count}, 32'd1);
        @(negedge clk); wr_byte = 8'hFF;
        chk("t6 count held on write+pop", {27'b0, count}, 32'd1);
        @(negedge clk); wr_en = 1'b0;
        chk("t2 count peak", {27'b0, count}, 32'd2);
        rx_frame(0, 8'hA5, 1'b0, 1'b0, "t2 f0", n0);
        rx_frame(0, 8'h3C, 1'b0, 1'b0, "t2 f1", n0b);
        chk("t2 contiguous f1", n0b - n0, 32'd40);
        rx_frame(0, 8'hFF, 1'b0, 1'b0, "t2 f2", n0c);
        chk("t2 contiguous f2", n0c - n0b, 32'd40);
        wait_done(0, c0);
        chk("t2 done delay", c0 - n0c, 32'd40);
        @(negedge clk);
        chk("t2 empty", {31'b0, empty}, 32'd1);
        repeat (5) @(negedge clk);

        // Test 3: fill FIFO while a frame is in flight, then overflow
        wr_en = 1'b1; wr_byte = 8'hEE;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    wr_byte = 8'(k);
                end
                @(negedge clk);
                chk("t3 count full", {27'b0, count}, 32'd16);
                chk("t3 full", {31'b0, full}, 32'd1);
                chk("t3 ovf not yet", {31'b0, ovf}, 32'd0);
                wr_byte = 8'h10;
                @(negedge clk); wr_en = 1'b0;
                chk("t3 ovf set", {31'b0, ovf}, 32'd1);
                chk("t3 count after drop", {27'b0, count}, 32'd16);
                clr_ovf = 1'b1;
                @(negedge clk);
                chk("t3 ovf cleared", {31'b0, ovf}, 32'd0);
                wr_en = 1'b1; wr_byte = 8'h11;
                @(negedge clk); wr_en = 1'b0; clr_ovf = 1'b0;
                chk("t3 set wins over clear", {31'b0, ovf}, 32'd1);
            end
            begin
                rx_frame(0, 8'hEE, 1'b0, 1'b0, "t3 pre", n0);
                for (int k = 0; k < 16; k++) begin
                    rx_frame(0, 8'(k), 1'b0, 1'b0, "t3 fifo", n0b);
                    chk("t3 contiguous", n0b - n0, 32'd40);
                    n0 = n0b;
                end
            end
        join
        wait_done(0, c0);
        @(negedge clk);
        chk("t3 empty at end", {31'b0, empty}, 32'd1);
        chk("t3 full at end", {31'b0, full}, 32'd0);
        chk("t3 ovf sticky", {31'b0, ovf}, 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        chk("t3 ovf final clear", {31'b0, ovf}, 32'd0);
        repeat (5) @(negedge clk);

        // Test 4: parity, 0x07 -> even 1, odd 0, 44-clock frame
        p_wr_en = 1'b1; wr_byte = 8'h07;
        @(negedge clk); p_wr_en = 1'b0;
        fork
            begin
                rx_frame(1, 8'h07, 1'b1, 1'b1, "t4 even", n1);
                wait_done(1, c1);
                chk("t4 even frame length", c1 - n1, 32'd44);
            end
            begin
                rx_frame(2, 8'h07, 1'b1, 1'b0, "t4 odd", n2);
                wait_done(2, c2);
                chk("t4 odd frame length", c2 - n2, 32'd44);
            end
        join
        chk("t4 main line idle", {31'b0, ser[0]}, 32'd1);
        repeat (5) @(negedge clk);

        // Test 5: async reset during data bit 3 with two bytes queued
        wr_en = 1'b1; wr_byte = 8'h81;
        @(negedge clk); wr_byte = 8'h42;
        @(negedge clk); wr_byte = 8'h24;
        @(negedge clk); wr_en = 1'b0;
        chk("t5 queued", {27'b0, count}, 32'd2);
        chk("t5 start low", {31'b0, ser[0]}, 32'd0);
        repeat (17) @(negedge clk);
        chk("t5 data bit 3", {31'b0, ser[0]}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 serial high async", {31'b0, ser[0]}, 32'd1);
        chk("t5 empty async", {31'b0, empty}, 32'd1);
        chk("t5 count async", {27'b0, count}, 32'd0);
        chk("t5 active async", {31'b0, act[0]}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (ser[0] !== 1'b1 || act[0] !== 1'b0) lows++;
        end
        chk("t5 no frame after reset", lows, 32'd0);
        chk("t5 empty after reset", {31'b0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
